// File: rtl/rv32i_types.sv
// Shared types for the memory-side cache arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32i_types;

    localparam int CACHELINE_BITS = 256;

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY,
        TURN
    } arb_state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } arb_port_t;

endpackage

// File: rtl/arb_priority.sv
// Grant select between icache and dcache request levels.
// Latency: combinational grant; the round-robin pointer updates on the grant edge.
// Backpressure: none here; the caller asserts grant_take only when it can accept a grant.
//
// Build option: ARB_RR_EN selects round-robin on a simultaneous request. The pointer
// resets to "last = D", so the first tie after reset goes to the icache. Without the
// macro the dcache always wins a tie and no pointer flop exists.
//
// Ports: clk, rst (sync, active-high); i_req, d_req request levels; grant_take marks
// the cycle a grant is actually consumed; grant_valid/grant_port give the selection.
module arb_priority
    import rv32i_types::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_req,
    input  logic      d_req,
    input  logic      grant_take,
    output logic      grant_valid,
    output arb_port_t grant_port
);

    assign grant_valid = i_req | d_req;

`ifdef ARB_RR_EN
    arb_port_t last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PORT_D;
        end else if (grant_take && grant_valid) begin
            last_q <= grant_port;
        end
    end

    always_comb begin
        grant_port = PORT_D;
        if (i_req && d_req) begin
            grant_port = (last_q == PORT_D) ? PORT_I : PORT_D;
        end else if (i_req) begin
            grant_port = PORT_I;
        end
    end
`else
    // Fixed priority: the dcache stalls the pipeline, so it wins every tie.
    logic unused_rr;
    assign unused_rr = ^{clk, rst, grant_take};

    assign grant_port = (i_req && !d_req) ? PORT_I : PORT_D;
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the icache and dcache, one line transfer at a time.
// Latency: request in IDLE at cycle 0 -> mem strobe from cycle 1; mem_resp at N -> *_resp at N,
//   TURN at N+1, IDLE at N+2 (next strobe no earlier than N+3).
// Backpressure: the loser simply keeps its request level asserted until it is granted.
//
// Build option: ARB_RR_EN (see arb_priority) selects round-robin vs. dcache-first ties.
//
// Ports: clk, rst (sync, active-high); i_pmem_* icache fill port; d_pmem_* dcache
// fill/writeback port; mem_* registered request to memory plus mem_rdata/mem_resp back.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int S_LINE = CACHELINE_BITS,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [XLEN-1:0]   i_pmem_address,
    input  logic              i_pmem_read,
    output logic [S_LINE-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic [XLEN-1:0]   d_pmem_address,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [S_LINE-1:0] d_pmem_wdata,
    output logic [S_LINE-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic [XLEN-1:0]   mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [S_LINE-1:0] mem_wdata,
    input  logic [S_LINE-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t state_q;
    arb_state_t state_d;

    logic       grant_valid;
    arb_port_t  grant_port;
    logic       grant_take;

    // Requests only count in IDLE; in TURN a cache may still be holding the
    // level of a request that was just completed.
    assign grant_take = (state_q == IDLE) && grant_valid;

    arb_priority u_prio (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_pmem_read),
        .d_req       (d_pmem_read | d_pmem_write),
        .grant_take  (grant_take),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = (grant_port == PORT_I) ? I_BUSY : D_BUSY;
                end
            end
            I_BUSY: begin
                i_pmem_resp = mem_resp;
                if (mem_resp) begin
                    state_d = TURN;
                end
            end
            D_BUSY: begin
                d_pmem_resp = mem_resp;
                if (mem_resp) begin
                    state_d = TURN;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latches double as the registered memory-side outputs. They load
    // only on a grant, so address/data/op stay frozen for the whole transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
        end else if (grant_take) begin
            if (grant_port == PORT_I) begin
                mem_address <= i_pmem_address;
                mem_read    <= 1'b1;
                mem_write   <= 1'b0;
            end else begin
                // Read and write together from the dcache is taken as a writeback.
                mem_address <= d_pmem_address;
                mem_wdata   <= d_pmem_wdata;
                mem_read    <= d_pmem_read & ~d_pmem_write;
                mem_write   <= d_pmem_write;
            end
        end else if (((state_q == I_BUSY) || (state_q == D_BUSY)) && mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

    // Only the owner sees resp, so both ports can share the read data.
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port arbiter that shares the single physical-memory port (256-bit lines, 32-bit byte addresses) between the instruction cache and the data cache. It sits between the two cache `pmem_*` interfaces and the memory or cacheline adaptor. It serializes line fills and writebacks, latching the winning request for its full duration and routing the response back to the requester that issued it.

## Interface
- S_LINE, 256, cacheline width in bits
- XLEN, 32, address width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_pmem_address  in  XLEN  icache line address (offset bits zero)
- i_pmem_read  in  1  icache fill request; held until i_pmem_resp
- i_pmem_rdata  out  S_LINE  fill data; valid when i_pmem_resp
- i_pmem_resp  out  1  one-cycle completion to icache
- d_pmem_address  in  XLEN  dcache line address
- d_pmem_read  in  1  dcache fill request
- d_pmem_write  in  1  dcache writeback request
- d_pmem_wdata  in  S_LINE  writeback data
- d_pmem_rdata  out  S_LINE  fill data; valid when d_pmem_resp
- d_pmem_resp  out  1  one-cycle completion to dcache
- mem_address  out  XLEN  registered request address
- mem_read  out  1  registered read strobe
- mem_write  out  1  registered write strobe
- mem_wdata  out  S_LINE  registered write data
- mem_rdata  in  S_LINE  memory read data
- mem_resp  in  1  memory completion pulse

## Operation
- States: IDLE, I_BUSY, D_BUSY, TURN.
- IDLE: if the icache requests and the dcache is idle, go to I_BUSY. If the dcache requests and the icache is idle, go to D_BUSY. If both request, the priority rule in Configuration decides.
- On grant, latch the requester's address. For the dcache, also latch the op and wdata. If d_pmem_read and d_pmem_write are both high, the op is a write.
- I_BUSY / D_BUSY: mem_* outputs are driven from the latches. Requester inputs are ignored while in these states.
- On mem_resp:
  - pulse the owner's *_resp in the same cycle;
  - drive mem_rdata onto the owner's *_rdata (combinational pass-through);
  - go to TURN.
- TURN: lasts exactly one cycle, with all mem strobes low. Request levels are ignored here, because a cache still drives its request in the cycle after it sees resp. Next state is IDLE.
- The non-owner's *_resp is always 0. Both *_rdata outputs may carry mem_rdata at all times.
- mem_resp received in IDLE or TURN is ignored.

## Timing
- Reset values:
  - state is IDLE;
  - mem_read, mem_write, i_pmem_resp and d_pmem_resp are 0;
  - mem_address and mem_wdata are 0;
  - the round-robin pointer is "last = D".
- Grant: request seen in IDLE at cycle 0 → mem_read or mem_write high from cycle 1.
- Completion: mem_resp at cycle N → *_resp at cycle N, TURN at N+1, IDLE at N+2. The earliest next mem strobe is at N+3.
- Minimum occupancy for back-to-back misses: memory latency plus 3 cycles.
- Reset mid-transaction: the state returns to IDLE on the next edge and all strobes drop. The in-flight transfer is abandoned. The memory side is reset by the same rst.
- The strobes do not change during a transaction. The address and data are stable from grant until resp.

## Configuration
- ARB_RR_EN defined:
  - on a simultaneous request in IDLE, grant the port that did not win the previous grant;
  - a one-bit pointer is updated at each grant;
  - the first simultaneous request after reset goes to the icache.
- ARB_RR_EN undefined:
  - fixed priority, and the dcache always wins a simultaneous request;
  - no pointer flop exists;
  - the icache can wait at most one dcache transaction per IDLE visit, because the dcache stalls the pipeline.

## Structure
- Shared package rv32i_types:
  - arb_state_t enum (IDLE, I_BUSY, D_BUSY, TURN);
  - arb_port_t enum (PORT_I, PORT_D);
  - localparam CACHELINE_BITS = 256.
- One sub-module, arb_priority: combinational grant select from the two request levels. Under ARB_RR_EN it also holds the last-winner flop. It outputs grant_valid and grant_port.
- The request latches, the FSM and the response routing live in cache_arbiter.

## Test plan
- Icache only: i_pmem_read=1 with address 0x0000_1040, memory resp after 5 cycles → mem_read=1 with mem_address=0x0000_1040 from cycle 1. i_pmem_resp pulses once and i_pmem_rdata equals mem_rdata. d_pmem_resp stays 0.
- Dcache writeback: d_pmem_write=1, address 0x8000_0020, wdata=256'hA5…A5 → mem_write=1 and mem_wdata matches. mem_read stays 0. d_pmem_resp is one cycle.
- Simultaneous requests from both caches, repeated twice:
  - with ARB_RR_EN, the order is I, D, I, D;
  - without it, the order is D, I, D, I.
  - In both cases each grant is separated by exactly 1 TURN cycle.
- Stale request: the icache holds i_pmem_read one cycle past resp → no second mem_read is issued. The next grant does not occur until IDLE.
- Assert rst in cycle 2 of a D_BUSY transaction → strobes are 0 on the next cycle and the state is IDLE. A mem_resp arriving later produces no *_resp.
- d_pmem_read and d_pmem_write asserted together → a write is issued and mem_read stays 0.
